datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 99 +++++++++
 tb/tb_datapath.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Accumulator-machine datapath: instruction register, program counter,
// accumulator and ALU, steered by strobes from an external controller.
module datapath (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_ir,
  input  logic       ld_ac,
  input  logic       ld_pc,
  input  logic       inc_pc,
  input  logic       halt,
  input  logic       data_e,
  input  logic       sel,
  input  logic [7:0] data_in,
  output logic [4:0] addr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [2:0] opcode,
  output logic       zero,
  output logic [7:0] acc
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned OW = 3;

  typedef enum logic [OW-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } op_e;

  logic [DW-1:0] ir_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] alu_c;
  logic [AW-1:0] operand_c;
  op_e           op_c;

  assign operand_c = ir_q[AW-1:0];
  assign op_c      = op_e'(ir_q[DW-1:AW]);

  // Instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else if (!halt && ld_ir) begin
      ir_q <= data_in;
    end
  end

  // Program counter; a jump load wins over an increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (!halt) begin
      if (ld_pc) begin
        pc_q <= operand_c;
      end else if (inc_pc) begin
        pc_q <= pc_q + AW'(1);
      end
    end
  end

  // ALU: result is truncated to the accumulator width
  always_comb begin
    alu_c = acc_q;
    unique case (op_c)
      OP_ADD:  alu_c = acc_q + data_in;
      OP_AND:  alu_c = acc_q & data_in;
      OP_XOR:  alu_c = acc_q ^ data_in;
      OP_LDA:  alu_c = data_in;
      OP_HLT, OP_SKZ, OP_STO, OP_JMP: alu_c = acc_q;
      default: alu_c = acc_q;
    endcase
  end

  // Accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (!halt && ld_ac) begin
      acc_q <= alu_c;
    end
  end

  // Zero flag looks at the stored accumulator, not the ALU output
  assign zero     = (acc_q == DW'(0));
  assign addr     = sel ? pc_q : operand_c;
  assign opcode   = ir_q[DW-1:AW];
  assign data_out = acc_q;
  assign data_oe  = data_e;
  assign acc      = acc_q;

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized checks of datapath against an arithmetic model.
module tb_datapath;

  logic       clk;
  logic       rst_n;
  logic       ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel;
  logic [7:0] data_in;
  logic [4:0] addr;
  logic [7:0] data_out;
  logic       data_oe;
  logic [2:0] opcode;
  logic       zero;
  logic [7:0] acc;

  int errors = 0;
  int checks = 0;

  // Model state as plain integers
  int m_ir, m_pc, m_acc;

  datapath dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_ir    (ld_ir),
    .ld_ac    (ld_ac),
    .ld_pc    (ld_pc),
    .inc_pc   (inc_pc),
    .halt     (halt),
    .data_e   (data_e),
    .sel      (sel),
    .data_in  (data_in),
    .addr     (addr),
    .data_out (data_out),
    .data_oe  (data_oe),
    .opcode   (opcode),
    .zero     (zero),
    .acc      (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int d);
    case (op)
      2:       return (a + d) % 256;
      3:       return a & d;
      4:       return a ^ d;
      5:       return d;
      default: return a;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".addr"},     32'(addr),     32'(sel ? m_pc : (m_ir % 32)));
    chk({tag, ".opcode"},   32'(opcode),   32'(m_ir / 32));
    chk({tag, ".zero"},     32'(zero),     32'(m_acc == 0));
    chk({tag, ".acc"},      32'(acc),      32'(m_acc));
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_acc));
    chk({tag, ".data_oe"},  32'(data_oe),  32'(data_e));
  endtask

  // One clock: model follows the strobes present at the edge
  task automatic step(input string tag);
    int n_ir, n_pc, n_acc;
    n_ir = m_ir; n_pc = m_pc; n_acc = m_acc;
    if (!rst_n) begin
      n_ir = 0; n_pc = 0; n_acc = 0;
    end else if (!halt) begin
      if (ld_ir) n_ir = int'(data_in);
      if (ld_ac) n_acc = alu_ref(m_ir / 32, m_acc, int'(data_in));
      if (ld_pc) n_pc = m_ir % 32;
      else if (inc_pc) n_pc = (m_pc + 1) % 32;
    end
    @(posedge clk);
    #1;
    m_ir = n_ir; m_pc = n_pc; m_acc = n_acc;
    check_all(tag);
  endtask

  task automatic idle();
    ld_ir = 0; ld_ac = 0; ld_pc = 0; inc_pc = 0; halt = 0;
  endtask

  initial begin
    rst_n = 0; idle(); data_e = 0; sel = 1; data_in = 8'h00;
    m_ir = 0; m_pc = 0; m_acc = 0;
    #12;
    chk("rst.addr_sel1", 32'(addr), 32'd0);
    chk("rst.opcode", 32'(opcode), 32'd0);
    chk("rst.zero", 32'(zero), 32'd1);
    chk("rst.acc", 32'(acc), 32'd0);
    sel = 0; #1;
    chk("rst.addr_sel0", 32'(addr), 32'd0);

    // Strobes during reset must not load anything
    ld_ir = 1; ld_ac = 1; inc_pc = 1; data_in = 8'hFF; sel = 1;
    step("rst_hold");
    idle(); rst_n = 1;
    step("post_rst_idle");

    // PC increment and wrap
    inc_pc = 1; sel = 1;
    for (int i = 1; i <= 33; i++) begin
      step("inc");
      chk("pc_wrap", 32'(addr), 32'(i % 32));
    end
    idle();

    // LDA then ADD with overflow
    ld_ir = 1; data_in = 8'hA0; step("lda_ir");
    chk("lda.opcode", 32'(opcode), 32'd5);
    idle(); ld_ac = 1; data_in = 8'h7F; step("lda_ac");
    chk("lda.acc", 32'(acc), 32'h7F);
    chk("lda.zero", 32'(zero), 32'd0);
    idle(); ld_ir = 1; data_in = 8'h43; step("add_ir");
    idle(); ld_ac = 1; data_in = 8'h81; step("add_ac");
    chk("add.acc", 32'(acc), 32'h00);
    chk("add.zero", 32'(zero), 32'd1);

    // JMP: load wins over increment
    idle(); ld_ir = 1; data_in = 8'hE9; step("jmp_ir");
    idle(); ld_pc = 1; inc_pc = 1; sel = 1; step("jmp_pc");
    chk("jmp.pc", 32'(addr), 32'd9);
    idle(); sel = 0; #1;
    chk("jmp.addr_sel0", 32'(addr), 32'd9);

    // Same-cycle ld_ir+ld_ac uses old opcode; ld_ir+ld_pc uses old operand
    ld_ir = 1; data_in = 8'hA0; step("lda2_ir");
    idle(); ld_ir = 1; ld_ac = 1; data_in = 8'h3C; step("ir_ac_same");
    chk("ir_ac.acc", 32'(acc), 32'h3C);
    chk("ir_ac.opcode", 32'(opcode), 32'd1);
    idle(); ld_ir = 1; ld_pc = 1; sel = 1; data_in = 8'h45; step("ir_pc_same");
    chk("ir_pc.pc", 32'(addr), 32'd28);

    // Halt freezes everything; combinational outputs still track
    idle(); halt = 1; ld_ir = 1; ld_ac = 1; inc_pc = 1; ld_pc = 1; data_in = 8'hFF;
    step("halt");
    chk("halt.acc", 32'(acc), 32'h3C);
    chk("halt.pc", 32'(addr), 32'd28);
    chk("halt.opcode", 32'(opcode), 32'd2);
    data_e = 1; sel = 0; #1;
    chk("halt.data_oe", 32'(data_oe), 32'd1);
    chk("halt.data_out", 32'(data_out), 32'h3C);
    chk("halt.addr_sel0", 32'(addr), 32'd5);
    data_e = 0;

    // Async reset between edges with acc=55, pc=12
    idle(); sel = 1; ld_ir = 1; data_in = 8'hAC; step("ar_ir");
    idle(); ld_ac = 1; ld_pc = 1; data_in = 8'h55; step("ar_ac");
    chk("ar.acc_pre", 32'(acc), 32'h55);
    chk("ar.pc_pre", 32'(addr), 32'd12);
    idle(); #2;
    rst_n = 0; #1;
    m_ir = 0; m_pc = 0; m_acc = 0;
    chk("ar.acc", 32'(acc), 32'd0);
    chk("ar.pc", 32'(addr), 32'd0);
    chk("ar.zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    rst_n = 1;
    step("ar_release");

    // Randomized strobes against the model
    for (int i = 0; i < 400; i++) begin
      ld_ir   = 1'($urandom_range(0, 1));
      ld_ac   = 1'($urandom_range(0, 1));
      ld_pc   = ($urandom_range(0, 5) == 0);
      inc_pc  = 1'($urandom_range(0, 1));
      halt    = ($urandom_range(0, 7) == 0);
      data_e  = 1'($urandom_range(0, 1));
      sel     = 1'($urandom_range(0, 1));
      data_in = 8'($urandom_range(0, 255));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
